dense_controller: RTL and testbench
===================================

# dense_controller

Sequencing FSM for the dense-layer datapath: drives its counter, accumulator-register and weight/bias-mux controls to compute all OUT_COUNT neurons (IN_COUNT MACs plus one bias add each) after a start request. It writes each neuron result to the output buffer under a ready/valid handshake and reports completion. It also cross-checks the datapath's terminal-count flags against its own shadow counters.

## Interface
- IN_COUNT, 784: inputs per neuron; must match the datapath.
- OUT_COUNT, 10: neurons per layer; must match the datapath.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE and DONE.
- outReady  in  1  output buffer accepts the current result.
- mulDone  in  1  datapath input counter at terminal count (IN_COUNT-1).
- calcDone  in  1  datapath output counter at terminal count (OUT_COUNT-1).
- putData  in  1  aliases calcDone; ignored.
- clear  out  1  clears both datapath counters.
- clearReg  out  1  clears the partial-product register.
- inCntEn  out  1  advances the input index.
- load  out  1  loads the partial-product register.
- WorB  out  1  0 = product to adder, 1 = bias to adder.
- outCntEn  out  1  advances the output index.
- outValid  out  1  the result on the datapath output bus is valid.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  one-cycle pulse when the layer finishes.
- seqErr  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, INIT, CLR, MAC, BIAS, DONE. Outputs are decoded from the state (Moore), except outCntEn, which is Mealy on outReady.
- IDLE: all outputs 0. If start=1, go to INIT.
- INIT: clear=1 and clearReg=1. Shadow counters reset to 0. Go to MAC.
- CLR: clearReg=1 only; the output counter is not cleared. Go to MAC.
- MAC: WorB=0, load=1, inCntEn=1.
  - The shadow input counter increments each cycle.
  - Leave MAC when mulDone=1 or the shadow count reaches IN_COUNT-1, then go to BIAS.
  - The shadow counter wraps to 0 on exit.
- BIAS: WorB=1 and outValid=1; load=0 and inCntEn=0.
  - While outReady=0: hold, with outputs unchanged.
  - When outReady=1: outCntEn=1 and the shadow output counter increments.
  - Then, if calcDone=1 or the shadow output count is OUT_COUNT-1, go to DONE; otherwise go to CLR.
- DONE: done=1 for exactly this state.
  - If start=1, go to INIT (back-to-back layers); otherwise go to IDLE.
- seqErr is set, and held until reset, when any of these occurs:
  - mulDone=1 in MAC with shadow count ≠ IN_COUNT-1;
  - mulDone=0 in MAC with shadow count = IN_COUNT-1;
  - the same two mismatch conditions for calcDone during the BIAS handshake.
- seqErr never blocks sequencing; the shadow terminal count forces progress.
- start is ignored while busy=1. A start held high through DONE causes a restart.
- Reset mid-operation: the FSM returns to IDLE asynchronously and all outputs go to 0, including seqErr. The datapath counters are reset by the same rst.

## Timing
- All outputs reset to 0; the state resets to IDLE.
- With start high in cycle 0, INIT occupies cycle 1.
- Neuron k (0-based) with no stalls:
  - CLR/INIT at cycle 1+k·(IN_COUNT+2);
  - MAC for the next IN_COUNT cycles;
  - BIAS for 1 cycle.
- The result write occurs in the BIAS cycle in which outValid and outReady are both 1. The output address equals k during that cycle.
- done is asserted in cycle OUT_COUNT·(IN_COUNT+2)+1, plus the total number of outReady stall cycles.
- The accumulator holds the sum of IN_COUNT products at BIAS entry. The register is not loaded in BIAS; the output data is accumulator + bias, combinationally.

## Test plan
- Nominal, with IN_COUNT=4, OUT_COUNT=3, outReady tied to 1:
  - pulse start;
  - 3 outValid/outCntEn strobes at cycles 6, 12, 18;
  - done at cycle 19;
  - inCntEn high for exactly 12 cycles;
  - seqErr=0.
- Backpressure: hold outReady=0 for 5 cycles in the second BIAS.
  - The state and outValid hold, and the address holds at 1.
  - done moves to cycle 24.
  - No extra load or inCntEn.
- Back-to-back: keep start high.
  - DONE goes directly to INIT, with clear=1 in the cycle after done.
  - The second done arrives 19 cycles after the first.
- Protocol error: force mulDone=1 at the second MAC cycle.
  - seqErr rises in the next cycle and stays high.
  - The FSM still leaves MAC on that mulDone.
- Missing flag: hold mulDone=0.
  - The shadow count forces BIAS after 4 MAC cycles.
  - seqErr=1, and done still arrives at cycle 19.
- Reset mid-MAC: drop rst low in cycle 8.
  - All outputs are 0 immediately and the FSM is in IDLE.
  - start is ignored until rst is released; a start after release gives a nominal run.

Source files
------------

// File: rtl/dense_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dense_controller : sequencing FSM for the dense-layer MAC/bias datapath
// Revision 1.0
// ---------------------------------------------------------------------------
module dense_controller #(
  parameter int IN_COUNT  = 784,
  parameter int OUT_COUNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic outReady,
  input  logic mulDone,
  input  logic calcDone,
  input  logic putData,
  output logic clear,
  output logic clearReg,
  output logic inCntEn,
  output logic load,
  output logic WorB,
  output logic outCntEn,
  output logic outValid,
  output logic busy,
  output logic done,
  output logic seqErr
);

  localparam int IW = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
  localparam int OW = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1;
  localparam logic [IW-1:0] IN_LAST  = IW'(IN_COUNT - 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_COUNT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_CLR  = 3'd2;
  localparam logic [2:0] S_MAC  = 3'd3;
  localparam logic [2:0] S_BIAS = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic [IW-1:0] r_in_cnt;
  logic [OW-1:0] r_out_cnt;
  logic          r_seq_err;
  logic          w_in_last;
  logic          w_out_last;
  logic          w_mac_exit;
  logic          w_handshake;
  logic          w_unused;

  // putData duplicates calcDone on the datapath side
  assign w_unused    = putData;
  assign w_in_last   = (r_in_cnt == IN_LAST);
  assign w_out_last  = (r_out_cnt == OUT_LAST);
  assign w_mac_exit  = mulDone || w_in_last;
  assign w_handshake = (r_state == S_BIAS) && outReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = S_INIT;
      S_INIT: w_next_state = S_MAC;
      S_CLR:  w_next_state = S_MAC;
      S_MAC:  if (w_mac_exit) w_next_state = S_BIAS;
      S_BIAS: begin
        if (outReady) begin
          w_next_state = (calcDone || w_out_last) ? S_DONE : S_CLR;
        end
      end
      S_DONE: w_next_state = start ? S_INIT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Shadow counters mirror the datapath so a missing flag cannot stall the layer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_seq_err <= 1'b0;
    end else begin
      if (r_state == S_INIT) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end
      if (r_state == S_MAC) begin
        r_in_cnt <= w_mac_exit ? '0 : r_in_cnt + IW'(1);
        if (mulDone != w_in_last) r_seq_err <= 1'b1;
      end
      if (w_handshake) begin
        r_out_cnt <= w_out_last ? '0 : r_out_cnt + OW'(1);
        if (calcDone != w_out_last) r_seq_err <= 1'b1;
      end
    end
  end

  always_comb begin
    clear    = 1'b0;
    clearReg = 1'b0;
    inCntEn  = 1'b0;
    load     = 1'b0;
    WorB     = 1'b0;
    outValid = 1'b0;
    done     = 1'b0;
    busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    outCntEn = w_handshake;
    seqErr   = r_seq_err;
    case (r_state)
      S_INIT: begin
        clear    = 1'b1;
        clearReg = 1'b1;
      end
      S_CLR:  clearReg = 1'b1;
      S_MAC: begin
        load    = 1'b1;
        inCntEn = 1'b1;
      end
      S_BIAS: begin
        WorB     = 1'b1;
        outValid = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dense_controller.sv
`default_nettype none
// Directed bench for dense_controller with a small counter model standing in for the datapath.
module tb_dense_controller;

  localparam int IN  = 4;
  localparam int OUT = 3;
  localparam int B_CLEAR = 9, B_CLRREG = 8, B_INC = 7, B_LOAD = 6, B_WORB = 5;
  localparam int B_OCE = 4, B_OV = 3, B_BUSY = 2, B_DONE = 1, B_ERR = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic outReady = 1'b1;
  logic mulDone, calcDone;
  logic clear, clearReg, inCntEn, load, WorB, outCntEn, outValid, busy, done, seqErr;
  logic [9:0] outs;

  int in_idx, out_idx;
  int cyc = 0;
  int mode = 0;      // 0 normal flags, 1 force mulDone=1 at cycle fc, 2 hold mulDone=0
  int fc = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic [9:0] hist [0:63];
  int addr [0:63];
  int s1, s2, s3, d1;

  dense_controller #(.IN_COUNT(IN), .OUT_COUNT(OUT)) dut (
    .clk(clk), .rst(rst), .start(start), .outReady(outReady),
    .mulDone(mulDone), .calcDone(calcDone), .putData(calcDone),
    .clear(clear), .clearReg(clearReg), .inCntEn(inCntEn), .load(load),
    .WorB(WorB), .outCntEn(outCntEn), .outValid(outValid), .busy(busy),
    .done(done), .seqErr(seqErr)
  );

  always #5 clk = ~clk;

  assign outs = {clear, clearReg, inCntEn, load, WorB, outCntEn, outValid, busy, done, seqErr};
  assign mulDone  = (mode == 2) ? 1'b0 :
                    ((mode == 1) && (cyc == fc)) ? 1'b1 : (in_idx == IN - 1);
  assign calcDone = (out_idx == OUT - 1);

  // Datapath index counters, cleared by the same reset as the controller
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_idx  <= 0;
      out_idx <= 0;
    end else if (clear) begin
      in_idx  <= 0;
      out_idx <= 0;
    end else begin
      if (inCntEn)  in_idx  <= (in_idx == IN - 1) ? 0 : in_idx + 1;
      if (outCntEn) out_idx <= (out_idx == OUT - 1) ? 0 : out_idx + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_bit(input int b, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (hist[c][b]) n++;
    return n;
  endfunction

  function automatic int first_bit(input int b, input int from, input int hi);
    for (int c = from; c <= hi; c++) if (hist[c][b]) return c;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; mode = 0; outReady = 1'b1; cyc = 0;
    #3;
    check("reset_outputs", int'(outs), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Start is raised in cycle 0; outReady is low in cycles slo..shi
  task automatic run(input int ncyc, input int slo, input int shi, input bit keep);
    for (int c = 0; c < 64; c++) begin
      hist[c] = '0;
      addr[c] = 0;
    end
    cyc = 0; start = 1'b1; outReady = 1'b1;
    #1;
    hist[0] = outs; addr[0] = out_idx;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      cyc = i;
      if (!keep) start = 1'b0;
      outReady = !((i >= slo) && (i <= shi));
      #1;
      hist[i] = outs; addr[i] = out_idx;
    end
  endtask

  initial begin
    do_reset();

    // Nominal layer
    run(21, -1, -1, 1'b0);
    check("nom_idle_c0", int'(hist[0]), 0);
    check("nom_init_clear", first_bit(B_CLEAR, 0, 21), 1);
    check("nom_clear_count", cnt_bit(B_CLEAR, 0, 21), 1);
    check("nom_strobes", cnt_bit(B_OCE, 0, 21), 3);
    s1 = first_bit(B_OCE, 0, 21);
    s2 = first_bit(B_OCE, s1 + 1, 21);
    s3 = first_bit(B_OCE, s2 + 1, 21);
    check("nom_strobe0", s1, 6);
    check("nom_strobe1", s2, 12);
    check("nom_strobe2", s3, 18);
    check("nom_addr0", addr[6], 0);
    check("nom_addr1", addr[12], 1);
    check("nom_addr2", addr[18], 2);
    check("nom_valid_cycles", cnt_bit(B_OV, 0, 21), 3);
    check("nom_done_cycle", first_bit(B_DONE, 0, 21), 19);
    check("nom_done_count", cnt_bit(B_DONE, 0, 21), 1);
    check("nom_incnt", cnt_bit(B_INC, 0, 21), 12);
    check("nom_load", cnt_bit(B_LOAD, 0, 21), 12);
    check("nom_busy_c18", int'(hist[18][B_BUSY]), 1);
    check("nom_idle_c20", int'(hist[20]), 0);
    check("nom_seqerr", cnt_bit(B_ERR, 0, 21), 0);

    // Backpressure in the second BIAS
    do_reset();
    run(26, 12, 16, 1'b0);
    check("bp_valid_cycles", cnt_bit(B_OV, 12, 17), 6);
    check("bp_addr_hold", addr[16], 1);
    check("bp_no_strobe_stall", cnt_bit(B_OCE, 12, 16), 0);
    check("bp_strobe1", first_bit(B_OCE, 7, 26), 17);
    check("bp_strobe2", first_bit(B_OCE, 18, 26), 23);
    check("bp_done_cycle", first_bit(B_DONE, 0, 26), 24);
    check("bp_incnt", cnt_bit(B_INC, 0, 26), 12);
    check("bp_load", cnt_bit(B_LOAD, 0, 26), 12);
    check("bp_seqerr", int'(hist[26][B_ERR]), 0);

    // Back-to-back layers with start held high
    do_reset();
    run(40, -1, -1, 1'b1);
    d1 = first_bit(B_DONE, 0, 40);
    check("b2b_done1", d1, 19);
    check("b2b_clear_after_done", int'(hist[20][B_CLEAR]), 1);
    check("b2b_done2", first_bit(B_DONE, d1 + 1, 40), 38);
    check("b2b_seqerr", cnt_bit(B_ERR, 0, 40), 0);

    // Early mulDone in the second MAC cycle
    do_reset();
    mode = 1; fc = 3;
    run(8, -1, -1, 1'b0);
    check("err_before", int'(hist[3][B_ERR]), 0);
    check("err_rise", int'(hist[4][B_ERR]), 1);
    check("err_bias_c4", int'(hist[4][B_WORB]), 1);
    check("err_mac_cycles", cnt_bit(B_INC, 0, 4), 2);
    check("err_sticky", int'(hist[8][B_ERR]), 1);

    // Missing mulDone: shadow count forces progress
    do_reset();
    mode = 2;
    run(20, -1, -1, 1'b0);
    check("miss_mac_cycles", cnt_bit(B_INC, 2, 6), 4);
    check("miss_bias_c6", int'(hist[6][B_WORB]), 1);
    check("miss_err_c5", int'(hist[5][B_ERR]), 0);
    check("miss_err_c6", int'(hist[6][B_ERR]), 1);
    check("miss_done_cycle", first_bit(B_DONE, 0, 20), 19);

    // Reset in the middle of MAC
    do_reset();
    run(8, -1, -1, 1'b0);
    check("rst_mac_active", int'(hist[8][B_LOAD]), 1);
    rst = 1'b0;
    #1;
    check("rst_async_outs", int'(outs), 0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("rst_start_ignored", int'(outs), 0);
    check("rst_out_idx", out_idx, 0);
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("rst_released_idle", int'(outs), 0);
    run(21, -1, -1, 1'b0);
    check("rst_rerun_done", first_bit(B_DONE, 0, 21), 19);
    check("rst_rerun_strobes", cnt_bit(B_OCE, 0, 21), 3);
    check("rst_rerun_seqerr", cnt_bit(B_ERR, 0, 21), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
